// File: rtl/stim_pkg.sv
// Shared definitions for the stimulation engines and their register file:
// default field widths, polarity constant and the pulse sequencer state encoding.
package stim_pkg;

  localparam int DEF_PULSE_W    = 14;
  localparam int DEF_INTERVAL_W = 16;
  localparam int DEF_NUM_W      = 12;
  localparam int DEF_AMP_W      = 8;

  localparam logic POL_CATH_FIRST = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_GAP  = 3'd2,
    ST_PH2  = 3'd3,
    ST_INTV = 3'd4
  } state_t;

endpackage

// File: rtl/stim_dur_cnt.sv
// Loadable duration down-counter. A load of width W sets it to max(W,1)-1;
// zero flags the final cycle of the current state.
module stim_dur_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Width 0 and width 1 both load 0, so a zero width still lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= (load_val == '0) ? '0 : load_val - W'(1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/stim_pulse_seq.sv
// Stimulation pulse-train sequencer for one engine: shadows the parameter set on
// start and plays biphasic or monophasic pulses with fully registered outputs.
module stim_pulse_seq
  import stim_pkg::*;
#(
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int INTERVAL_W = DEF_INTERVAL_W,
  parameter int NUM_W      = DEF_NUM_W,
  parameter int AMP_W      = DEF_AMP_W
) (
  input  logic                  clk_stim_i,
  input  logic                  reset_stim_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic [AMP_W-1:0]      ia_i,
  input  logic [AMP_W-1:0]      ic_i,
  input  logic [PULSE_W-1:0]    pulse_wc_i,
  input  logic [PULSE_W-1:0]    pulse_gap_i,
  input  logic [PULSE_W-1:0]    pulse_wa_i,
  input  logic [NUM_W-1:0]      pulse_num_i,
  input  logic                  pol_i,
  input  logic                  monophasic_i,
  output logic                  cath_en_o,
  output logic                  anod_en_o,
  output logic [AMP_W-1:0]      dac_code_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_W-1:0]      pulse_cnt_o
);

  state_t state_reg, state_next;

  logic [PULSE_W-1:0]    wc_reg, gap_reg, wa_reg;
  logic [INTERVAL_W-1:0] interval_reg;
  logic [NUM_W-1:0]      num_reg;
  logic [AMP_W-1:0]      ia_reg, ic_reg;
  logic                  pol_reg, mono_reg;

  logic [NUM_W-1:0]      pulse_cnt_reg, pulse_cnt_next, cnt_inc;
  logic                  latch, pulse_end;
  logic                  cnt_load, cnt_zero;
  logic [INTERVAL_W-1:0] cnt_load_val;

  logic                  pol_eff, ph1_cath;
  logic [AMP_W-1:0]      ia_eff, ic_eff;
  logic                  cath_next, anod_next, busy_next, done_next;
  logic                  cath_reg, anod_reg, busy_reg, done_reg;
  logic [AMP_W-1:0]      dac_next, dac_reg;

  stim_dur_cnt #(.W(INTERVAL_W)) u_dur_cnt (
    .clk      (clk_stim_i),
    .rst      (reset_stim_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next     = state_reg;
    pulse_cnt_next = pulse_cnt_reg;
    done_next      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    latch          = 1'b0;
    pulse_end      = 1'b0;
    cnt_inc        = pulse_cnt_reg + NUM_W'(1);

    // Abort has priority everywhere, including over a start seen in IDLE.
    if (stop_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            pulse_cnt_next = '0;
            if (pulse_num_i == '0) begin
              done_next = 1'b1;
            end else begin
              latch        = 1'b1;
              state_next   = ST_PH1;
              cnt_load     = 1'b1;
              cnt_load_val = (pol_i == POL_CATH_FIRST) ? INTERVAL_W'(pulse_wc_i)
                                                       : INTERVAL_W'(pulse_wa_i);
            end
          end
        end
        ST_PH1: begin
          if (cnt_zero) begin
            if (mono_reg) begin
              pulse_end = 1'b1;
            end else begin
              state_next   = ST_GAP;
              cnt_load     = 1'b1;
              cnt_load_val = INTERVAL_W'(gap_reg);
            end
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_next   = ST_PH2;
            cnt_load     = 1'b1;
            cnt_load_val = (pol_reg == POL_CATH_FIRST) ? INTERVAL_W'(wa_reg)
                                                       : INTERVAL_W'(wc_reg);
          end
        end
        ST_PH2: begin
          if (cnt_zero) begin
            pulse_end = 1'b1;
          end
        end
        ST_INTV: begin
          if (cnt_zero) begin
            state_next   = ST_PH1;
            cnt_load     = 1'b1;
            cnt_load_val = (pol_reg == POL_CATH_FIRST) ? INTERVAL_W'(wc_reg)
                                                       : INTERVAL_W'(wa_reg);
          end
        end
        default: state_next = ST_IDLE;
      endcase

      if (pulse_end) begin
        pulse_cnt_next = cnt_inc;
        if (cnt_inc == num_reg) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next   = ST_INTV;
          cnt_load     = 1'b1;
          cnt_load_val = interval_reg;
        end
      end
    end
  end

  // Outputs are decoded from the next state so the registered enables line up
  // with the state itself; on the start cycle the shadows are not yet loaded.
  always_comb begin
    pol_eff   = latch ? pol_i : pol_reg;
    ia_eff    = latch ? ia_i : ia_reg;
    ic_eff    = latch ? ic_i : ic_reg;
    ph1_cath  = (pol_eff == POL_CATH_FIRST);
    cath_next = ((state_next == ST_PH1) && ph1_cath) || ((state_next == ST_PH2) && !ph1_cath);
    anod_next = ((state_next == ST_PH1) && !ph1_cath) || ((state_next == ST_PH2) && ph1_cath);
    busy_next = (state_next != ST_IDLE);
    dac_next  = cath_next ? ic_eff : (anod_next ? ia_eff : '0);
  end

  always_ff @(posedge clk_stim_i or posedge reset_stim_i) begin
    if (reset_stim_i) begin
      state_reg     <= ST_IDLE;
      pulse_cnt_reg <= '0;
      cath_reg      <= 1'b0;
      anod_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dac_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pulse_cnt_reg <= pulse_cnt_next;
      cath_reg      <= cath_next;
      anod_reg      <= anod_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      dac_reg       <= dac_next;
    end
  end

  always_ff @(posedge clk_stim_i or posedge reset_stim_i) begin
    if (reset_stim_i) begin
      wc_reg       <= '0;
      gap_reg      <= '0;
      wa_reg       <= '0;
      interval_reg <= '0;
      num_reg      <= '0;
      ia_reg       <= '0;
      ic_reg       <= '0;
      pol_reg      <= 1'b0;
      mono_reg     <= 1'b0;
    end else if (latch) begin
      wc_reg       <= pulse_wc_i;
      gap_reg      <= pulse_gap_i;
      wa_reg       <= pulse_wa_i;
      interval_reg <= interval_i;
      num_reg      <= pulse_num_i;
      ia_reg       <= ia_i;
      ic_reg       <= ic_i;
      pol_reg      <= pol_i;
      mono_reg     <= monophasic_i;
    end
  end

  assign cath_en_o   = cath_reg;
  assign anod_en_o   = anod_reg;
  assign dac_code_o  = dac_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign pulse_cnt_o = pulse_cnt_reg;

endmodule

// File: tb/tb_stim_pulse_seq.sv
// Scoreboard bench for stim_pulse_seq: a segment-level train model queues the
// expected output vector per cycle and an independent monitor compares them.
module tb_stim_pulse_seq;

  typedef struct packed {
    logic        cath;
    logic        anod;
    logic [7:0]  dac;
    logic        busy;
    logic        done;
    logic [11:0] cnt;
  } out_t;

  typedef struct {
    int unsigned cyc;
    out_t        o;
  } exp_t;

  logic        clk_stim_i   = 1'b0;
  logic        reset_stim_i = 1'b0;
  logic        start_i      = 1'b0;
  logic        stop_i       = 1'b0;
  logic [15:0] interval_i   = '0;
  logic [7:0]  ia_i         = '0;
  logic [7:0]  ic_i         = '0;
  logic [13:0] pulse_wc_i   = '0;
  logic [13:0] pulse_gap_i  = '0;
  logic [13:0] pulse_wa_i   = '0;
  logic [11:0] pulse_num_i  = '0;
  logic        pol_i        = 1'b0;
  logic        monophasic_i = 1'b0;
  logic        cath_en_o, anod_en_o, busy_o, done_o;
  logic [7:0]  dac_code_o;
  logic [11:0] pulse_cnt_o;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          txn      = 0;
  int unsigned model_cnt = 0;
  exp_t        exp_q[$];
  out_t        plan_q[$];

  stim_pulse_seq dut (
    .clk_stim_i   (clk_stim_i),
    .reset_stim_i (reset_stim_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .interval_i   (interval_i),
    .ia_i         (ia_i),
    .ic_i         (ic_i),
    .pulse_wc_i   (pulse_wc_i),
    .pulse_gap_i  (pulse_gap_i),
    .pulse_wa_i   (pulse_wa_i),
    .pulse_num_i  (pulse_num_i),
    .pol_i        (pol_i),
    .monophasic_i (monophasic_i),
    .cath_en_o    (cath_en_o),
    .anod_en_o    (anod_en_o),
    .dac_code_o   (dac_code_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pulse_cnt_o  (pulse_cnt_o)
  );

  always #5 clk_stim_i = ~clk_stim_i;
  always @(posedge clk_stim_i) cyc <= cyc + 1;

  function automatic out_t mk(input bit c, input bit a, input logic [7:0] d,
                              input bit b, input bit dn, input int unsigned n);
    out_t o;
    o.cath = c; o.anod = a; o.dac = d; o.busy = b; o.done = dn; o.cnt = n[11:0];
    return o;
  endfunction

  function automatic out_t dut_out();
    return mk(cath_en_o, anod_en_o, dac_code_o, busy_o, done_o, int'(pulse_cnt_o));
  endfunction

  function automatic int unsigned cl(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  // Monitor: compares whatever expectation is tagged for the current cycle.
  initial begin : monitor
    exp_t e;
    out_t got;
    forever begin
      @(posedge clk_stim_i);
      #3;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL stale_expect cyc=%0d tag=%0d", cyc, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        got = dut_out();
        checks++;
        if (got !== e.o) begin
          failures++;
          $display("FAIL outputs cyc=%0d got cath=%0b anod=%0b dac=%02h busy=%0b done=%0b cnt=%0d required cath=%0b anod=%0b dac=%02h busy=%0b done=%0b cnt=%0d",
                   cyc, got.cath, got.anod, got.dac, got.busy, got.done, got.cnt,
                   e.o.cath, e.o.anod, e.o.dac, e.o.busy, e.o.done, e.o.cnt);
        end
      end
    end
  end

  // Queue the output expected after the coming edge, then move past that edge.
  task automatic push_step(input out_t o);
    exp_t e;
    e.cyc = cyc + 1;
    e.o   = o;
    exp_q.push_back(e);
    @(posedge clk_stim_i);
    #1;
  endtask

  task automatic check_zero(input string name);
    out_t got;
    got = dut_out();
    checks++;
    if (got !== mk(0, 0, 8'h00, 0, 0, 0)) begin
      failures++;
      $display("FAIL %s got cath=%0b anod=%0b dac=%02h busy=%0b done=%0b cnt=%0d required all zero",
               name, got.cath, got.anod, got.dac, got.busy, got.done, got.cnt);
    end
  endtask

  task automatic add_seg(input int unsigned w, input out_t o);
    for (int k = 0; k < int'(cl(w)); k++) plan_q.push_back(o);
  endtask

  task automatic randomize_params();
    interval_i   = 16'($urandom_range(0, 20));
    ia_i         = 8'($urandom);
    ic_i         = 8'($urandom);
    pulse_wc_i   = 14'($urandom_range(0, 20));
    pulse_gap_i  = 14'($urandom_range(0, 20));
    pulse_wa_i   = 14'($urandom_range(0, 20));
    pulse_num_i  = 12'($urandom_range(0, 9));
    pol_i        = 1'($urandom_range(0, 1));
    monophasic_i = 1'($urandom_range(0, 1));
  endtask

  // stop_at: >=1 fixed stop iteration, -2 random, -1 none. rst_at: >=1 reset then, else none.
  task automatic run_train(input int unsigned num, input int unsigned wc, input int unsigned gap,
                           input int unsigned wa, input int unsigned iv,
                           input logic [7:0] ia, input logic [7:0] ic, input bit pol, input bit mono,
                           input int stop_at, input int rst_at, input bit noisy);
    int s;
    logic [7:0] d1, d2;
    s  = stop_at;
    d1 = pol ? ia : ic;
    d2 = pol ? ic : ia;
    plan_q.delete();
    if (num == 0) begin
      plan_q.push_back(mk(0, 0, 8'h00, 0, 1, 0));
    end else begin
      for (int unsigned p = 0; p < num; p++) begin
        add_seg(pol ? wa : wc, mk(!pol, pol, d1, 1, 0, p));
        if (!mono) begin
          add_seg(gap, mk(0, 0, 8'h00, 1, 0, p));
          add_seg(pol ? wc : wa, mk(pol, !pol, d2, 1, 0, p));
        end
        if (p + 1 < num) add_seg(iv, mk(0, 0, 8'h00, 1, 0, p + 1));
      end
      plan_q.push_back(mk(0, 0, 8'h00, 0, 1, num));
    end
    if (s == -2) s = (plan_q.size() > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, plan_q.size() - 1) : -1;
    txn++;
    $display("txn %0d: num=%0d wc=%0d gap=%0d wa=%0d intv=%0d pol=%0b mono=%0b ia=%02h ic=%02h stop_at=%0d rst_at=%0d cycles=%0d",
             txn, num, wc, gap, wa, iv, pol, mono, ia, ic, s, rst_at, plan_q.size());
    for (int j = 0; j < plan_q.size(); j++) begin
      if (j == 0) begin
        interval_i = iv[15:0]; ia_i = ia; ic_i = ic;
        pulse_wc_i = wc[13:0]; pulse_gap_i = gap[13:0]; pulse_wa_i = wa[13:0];
        pulse_num_i = num[11:0]; pol_i = pol; monophasic_i = mono;
        start_i = 1'b1; stop_i = 1'b0;
      end else begin
        start_i = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (noisy) randomize_params();
        stop_i = (j == s);
      end
      if (j == rst_at) begin
        start_i = 1'b0; stop_i = 1'b0;
        #4;
        reset_stim_i = 1'b1;
        #1;
        check_zero("reset_async");
        exp_q.delete();
        @(posedge clk_stim_i);
        #1;
        reset_stim_i = 1'b0;
        model_cnt = 0;
        return;
      end
      if (j == s) begin
        model_cnt = plan_q[j-1].cnt;
        push_step(mk(0, 0, 8'h00, 0, 0, model_cnt));
        break;
      end
      push_step(plan_q[j]);
      model_cnt = plan_q[j].cnt;
    end
    // Idle: a stop (optionally with a start) must change nothing.
    stop_i = 1'b1;
    start_i = 1'($urandom_range(0, 1));
    pulse_num_i = 12'($urandom_range(1, 3));
    push_step(mk(0, 0, 8'h00, 0, 0, model_cnt));
    stop_i = 1'b0; start_i = 1'b0;
    push_step(mk(0, 0, 8'h00, 0, 0, model_cnt));
  endtask

  initial begin : driver
    #1;
    reset_stim_i = 1'b1;
    #1;
    check_zero("reset_init");
    @(posedge clk_stim_i);
    @(posedge clk_stim_i);
    #1;
    reset_stim_i = 1'b0;
    model_cnt = 0;
    push_step(mk(0, 0, 8'h00, 0, 0, 0));

    // Directed cases from the test plan.
    run_train(2, 3, 2, 4, 5, 8'h20, 8'h40, 1'b0, 1'b0, -1, -1, 1'b0);
    run_train(3, 5, 7, 2, 1, 8'h33, 8'h44, 1'b1, 1'b1, -1, -1, 1'b0);
    run_train(1, 0, 0, 0, 0, 8'h11, 8'h22, 1'b0, 1'b0, -1, -1, 1'b0);
    run_train(0, 3, 2, 4, 5, 8'h20, 8'h40, 1'b0, 1'b0, -1, -1, 1'b0);
    run_train(2, 3, 2, 4, 5, 8'h20, 8'h40, 1'b0, 1'b0, 21, -1, 1'b1);
    run_train(1, 3, 2, 4, 5, 8'h20, 8'h40, 1'b0, 1'b0, -1, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_train($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 6), $urandom_range(0, 5), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -2, -1, 1'b1);
    end

    // Reset while in the interphase gap, then a normal train afterwards.
    run_train(2, 3, 3, 2, 2, 8'h5A, 8'hA5, 1'b0, 1'b0, -1, 5, 1'b0);
    push_step(mk(0, 0, 8'h00, 0, 0, 0));
    run_train(1, 2, 1, 2, 0, 8'h01, 8'h02, 1'b1, 1'b0, -1, -1, 1'b0);

    repeat (3) @(posedge clk_stim_i);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
